// File: rtl/fill_valve_arbiter_pkg.sv
// Shared types and default constants for the fill-valve arbiter and related
// shared-resource arbiters.
package fill_valve_arbiter_pkg;

  localparam int unsigned DEF_N_MACH   = 4;
  localparam int unsigned DEF_MAX_HOLD = 16;
  localparam int unsigned DEF_GAP      = 2;

  localparam int unsigned OWNER_W = 3;
  localparam int unsigned HOLD_W  = 6;
  localparam int unsigned GAP_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    STALL,
    SETTLE
  } fv_state_e;

endpackage

// File: rtl/fill_valve_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping. Shared with other resource arbiters.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Two passes avoid modulo arithmetic: upper segment from ptr, then wrap.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[i] && (32'(ptr) <= i)) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fill_valve_arbiter.sv
// Round-robin owner of the shared mains inlet valve with hold limit, settle
// gap and supply-loss stall. Define FILL_STATS_EN for per-machine grant counters.
// The per-machine release input is named rel because release is reserved.
module fill_valve_arbiter
  import fill_valve_arbiter_pkg::*;
#(
  parameter int unsigned N_MACH   = DEF_N_MACH,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned GAP      = DEF_GAP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_MACH-1:0]     req,
  input  logic [N_MACH-1:0]     rel,
  input  logic                  supply_ok,
  output logic [N_MACH-1:0]     grant,
  output logic                  valve_open,
  output logic [N_MACH-1:0]     preempt,
  output logic [OWNER_W-1:0]    owner_id,
  output logic                  busy,
  output logic [8*N_MACH-1:0]   grant_count
);

  fv_state_e           state, state_nx;
  logic [OWNER_W-1:0]  rr_ptr, rr_ptr_nx;
  logic [OWNER_W-1:0]  owner_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_nx;
  logic [N_MACH-1:0]   grant_nx, preempt_nx;
  logic                valve_nx, busy_nx;
  logic [OWNER_W-1:0]  win_idx;
  logic                win_valid;
  logic                owner_done;
  logic                go_settle;

  rr_pick #(
    .N (N_MACH),
    .W (OWNER_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // grant is one-hot on the owner while HOLD/STALL, so masking selects its bits
  assign owner_done = |((rel | ~req) & grant);

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    valve_nx    = valve_open;
    preempt_nx  = '0;
    owner_nx    = owner_id;
    rr_ptr_nx   = rr_ptr;
    hold_cnt_nx = hold_cnt;
    gap_cnt_nx  = gap_cnt;
    go_settle   = 1'b0;

    unique case (state)
      IDLE: begin
        if (win_valid && supply_ok) begin
          state_nx    = HOLD;
          owner_nx    = win_idx;
          valve_nx    = 1'b1;
          hold_cnt_nx = '0;
          for (int unsigned i = 0; i < N_MACH; i++) begin
            grant_nx[i] = (win_idx == OWNER_W'(i));
          end
        end
      end
      HOLD: begin
        hold_cnt_nx = hold_cnt + HOLD_W'(1);
        if (owner_done) begin
          go_settle = 1'b1;
        end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          go_settle  = 1'b1;
          preempt_nx = grant;
        end else if (!supply_ok) begin
          state_nx = STALL;
          valve_nx = 1'b0;
        end
      end
      STALL: begin
        if (owner_done) begin
          go_settle = 1'b1;
        end else if (supply_ok) begin
          state_nx = HOLD;
          valve_nx = 1'b1;
        end
      end
      SETTLE: begin
        if (gap_cnt == GAP_W'(GAP - 1)) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    if (go_settle) begin
      state_nx   = SETTLE;
      grant_nx   = '0;
      valve_nx   = 1'b0;
      owner_nx   = '0;
      gap_cnt_nx = '0;
      rr_ptr_nx  = (owner_id == OWNER_W'(N_MACH - 1)) ? '0 : owner_id + OWNER_W'(1);
    end

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      valve_open <= 1'b0;
      preempt    <= '0;
      owner_id   <= '0;
      busy       <= 1'b0;
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      valve_open <= valve_nx;
      preempt    <= preempt_nx;
      owner_id   <= owner_nx;
      busy       <= busy_nx;
      rr_ptr     <= rr_ptr_nx;
      hold_cnt   <= hold_cnt_nx;
      gap_cnt    <= gap_cnt_nx;
    end
  end

`ifdef FILL_STATS_EN
  logic [7:0] stat_cnt [N_MACH];
  logic       grant_issue;

  assign grant_issue = (state == IDLE) && (state_nx == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_MACH; i++) begin
        stat_cnt[i] <= '0;
      end
    end else if (grant_issue) begin
      for (int unsigned i = 0; i < N_MACH; i++) begin
        if (grant_nx[i] && (stat_cnt[i] != '1)) begin
          stat_cnt[i] <= stat_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < N_MACH; i++) begin
      grant_count[8*i +: 8] = stat_cnt[i];
    end
  end
`else
  assign grant_count = '0;
`endif

  a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_valve_owner  : assert property (@(posedge clk) disable iff (reset) valve_open |-> (grant != '0));

endmodule

// File: tb/tb_fill_valve_arbiter.sv
// Randomized and directed bench for fill_valve_arbiter against a
// rule-level ownership model.
module tb_fill_valve_arbiter;

  localparam int N  = 4;
  localparam int MH = 16;
  localparam int G  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, rel, grant, preempt;
  logic           supply_ok, valve_open, busy;
  logic [2:0]     owner_id;
  logic [8*N-1:0] grant_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the valve, whether water flows, how long it has flowed,
  // how many closed gap cycles remain before the next pick.
  int           m_owner;
  bit           m_open;
  int           m_used;
  int           m_settle;
  int           m_ptr;
  logic [N-1:0] m_pre;
  int           m_cnt [N];

  int cnt_open, cnt_stall;

  always #5 clk = ~clk;

  fill_valve_arbiter #(
    .N_MACH   (N),
    .MAX_HOLD (MH),
    .GAP      (G)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rel         (rel),
    .supply_ok   (supply_ok),
    .grant       (grant),
    .valve_open  (valve_open),
    .preempt     (preempt),
    .owner_id    (owner_id),
    .busy        (busy),
    .grant_count (grant_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner  = -1;
    m_open   = 1'b0;
    m_used   = 0;
    m_settle = 0;
    m_ptr    = 0;
    m_pre    = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_handover();
    m_ptr    = (m_owner + 1) % N;
    m_owner  = -1;
    m_open   = 1'b0;
    m_settle = G;
  endfunction

  function automatic void model_step();
    logic [N-1:0] pre;
    bit           done;
    int           c;
    pre = '0;
    if (m_owner >= 0) begin
      done = rel[m_owner] || !req[m_owner];
      if (m_open) begin
        m_used++;
        if (done) model_handover();
        else if (m_used == MH) begin
          pre[m_owner] = 1'b1;
          model_handover();
        end else if (!supply_ok) m_open = 1'b0;
      end else begin
        if (done) model_handover();
        else if (supply_ok) m_open = 1'b1;
      end
    end else if (m_settle > 0) begin
      m_settle--;
    end else if (supply_ok && (req != '0)) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_open  = 1'b1;
          m_used  = 0;
          if (m_cnt[c] < 255) m_cnt[c]++;
        end
      end
    end
    m_pre = pre;
  endfunction

  function automatic logic [8*N-1:0] exp_count();
    logic [8*N-1:0] v;
    v = '0;
`ifdef FILL_STATS_EN
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'(m_cnt[i]);
`endif
    return v;
  endfunction

  task automatic cycle();
    logic [N-1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_owner >= 0) ? (4'(1) << m_owner) : '0;
    check("grant", 64'(grant), 64'(eg));
    check("valve_open", 64'(valve_open), 64'(m_open));
    check("preempt", 64'(preempt), 64'(m_pre));
    check("owner_id", 64'(owner_id), 64'((m_owner >= 0) ? m_owner : 0));
    check("busy", 64'(busy), 64'((m_owner >= 0) || (m_settle > 0)));
    check("grant_count", 64'(grant_count), 64'(exp_count()));
    check("onehot0", 64'($onehot0(grant)), 64'(1));
  endtask

  task automatic step_count();
    cycle();
    if (valve_open) cnt_open++;
    if ((grant != '0) && !valve_open) cnt_stall++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    rel       = '0;
    supply_ok = 1'b1;
    model_reset();
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_valve", 64'(valve_open), 64'(0));
    check("rst_preempt", 64'(preempt), 64'(0));
    check("rst_owner", 64'(owner_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_count", 64'(grant_count), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    int k;
    k = 0;
    while (grant == '0 && k < 40) begin
      cycle();
      k++;
    end
    check("wait_grant_timeout", 64'(grant != '0), 64'(1));
    g = grant;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] exp_order [5];
    int           k, closed;
    bit           pre_seen;

    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Single requester: grant after 1 cycle, release after 5, GAP+1 closed.
    do_reset();
    req = 4'b0001;
    repeat (5) cycle();
    rel = 4'b0001;
    req = '0;
    cycle();
    rel = '0;
    repeat (4) cycle();

    // Round-robin fairness with all four requesting.
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_grant(g);
      check("rr_order", 64'(g), 64'(exp_order[j]));
      cycle();
      cycle();
      rel = g;
      cycle();
      rel = '0;
    end
    req = '0;
    repeat (4) cycle();

    // Hold limit and regrant to the sole requester.
    do_reset();
    req      = 4'b0100;
    cnt_open = 0;
    pre_seen = 1'b0;
    k        = 0;
    while (!pre_seen && k < 60) begin
      cycle();
      k++;
      if (preempt != '0) pre_seen = 1'b1;
      else if (valve_open) cnt_open++;
    end
    check("limit_open_cycles", 64'(cnt_open), 64'(MH));
    check("limit_preempt", 64'(preempt), 64'(4'b0100));
    closed = 0;
    k      = 0;
    while (!valve_open && k < 20) begin
      closed++;
      cycle();
      k++;
    end
    check("regrant_gap", 64'(closed), 64'(G + 1));
    check("regrant_owner", 64'(grant), 64'(4'b0100));
    req = '0;
    repeat (4) cycle();

    // Pressure loss at hold_cnt=5 for 4 cycles.
    do_reset();
    req       = 4'b0001;
    cnt_open  = 0;
    cnt_stall = 0;
    repeat (6) step_count();
    supply_ok = 1'b0;
    repeat (4) step_count();
    supply_ok = 1'b1;
    k = 0;
    while (preempt == '0 && k < 40) begin
      step_count();
      k++;
    end
    check("stall_preempt", 64'(preempt), 64'(4'b0001));
    check("stall_open_total", 64'(cnt_open), 64'(MH));
    check("stall_closed", 64'(cnt_stall), 64'(4));
    req = '0;
    repeat (4) cycle();

    // Release coincident with the hold limit: no preempt.
    do_reset();
    req = 4'b0010;
    cycle();
    repeat (MH - 1) cycle();
    rel = 4'b0010;
    cycle();
    check("coinc_no_preempt", 64'(preempt), 64'(0));
    check("coinc_valve_closed", 64'(valve_open), 64'(0));
    rel = '0;
    req = '0;
    repeat (4) cycle();

    // Non-owner release ignored.
    do_reset();
    req = 4'b0001;
    cycle();
    rel = 4'b0010;
    cycle();
    cycle();
    check("nonowner_rel", 64'(grant), 64'(4'b0001));
    rel = '0;
    req = '0;
    repeat (4) cycle();

    // Asynchronous reset during HOLD.
    req = 4'b0001;
    cycle();
    cycle();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valve", 64'(valve_open), 64'(0));
    check("async_rst_grant", 64'(grant), 64'(0));
    model_reset();
    req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) cycle();

    // Statistics saturation: >300 short grants to machine 1.
    do_reset();
    req = 4'b0010;
    rel = 4'b0010;
    repeat (1250) cycle();
`ifdef FILL_STATS_EN
    check("stats_lane1", 64'(grant_count[15:8]), 64'(255));
`else
    check("stats_lane1", 64'(grant_count[15:8]), 64'(0));
`endif
    req = '0;
    rel = '0;
    repeat (4) cycle();

    // Randomized traffic.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 11) == 0) supply_ok = !supply_ok;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
        rel[i] = ($urandom_range(0, 9) == 0);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
